// File: rtl/dummy_hls_ip_package.sv
// Shared types for the dummy_hls_ip channel scheduler: FSM encoding and the
// control/flag bundles exchanged with the HWPE control wrapper.
package dummy_hls_ip_package;

  localparam int unsigned CH_SCHED_CNT_W = 16;

  typedef enum logic [2:0] {
    CS_IDLE      = 3'd0,
    CS_START     = 3'd1,
    CS_RUN       = 3'd2,
    CS_WAIT_DONE = 3'd3,
    CS_DONE      = 3'd4
  } ch_sched_state_t;

  typedef struct packed {
    logic                      start;
    logic [CH_SCHED_CNT_W-1:0] in_len;
    logic [CH_SCHED_CNT_W-1:0] out_len;
    logic                      in_en;
    logic                      out_en;
  } ctrl_ch_sched_t;

  typedef struct packed {
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [CH_SCHED_CNT_W-1:0] in_cnt;
    logic [CH_SCHED_CNT_W-1:0] out_cnt;
  } flags_ch_sched_t;

endpackage

// File: rtl/dummy_hls_ip_beat_cnt.sv
// Per-channel beat counter: latches the job length, counts accepted beats and
// stops at the length, so it can never wrap.
module dummy_hls_ip_beat_cnt
  import dummy_hls_ip_package::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_zero_i,
  input  logic             beat_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             act_o,
  output logic             fin_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  assign act_o = (cnt_q < len_q);
  assign cnt_o = cnt_q;
  // Length reached once the beat presented this cycle lands.
  assign fin_o = !act_o || (beat_i && ((cnt_q + CNT_W'(1)) == len_q));

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (clear_i) begin
      cnt_d = '0;
      len_d = '0;
    end else if (load_zero_i) begin
      cnt_d = '0;
      len_d = len_i;
    end else if (beat_i && act_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/dummy_hls_ip_ch_sched.sv
// Job sequencer in front of the dummy_hls_ip HLS core: drives ap_ctrl_hs and
// gates/counts the input and output streams against the programmed lengths.
//
// state     | meaning
// IDLE      | waiting for start_i while the core reports ap_idle
// START     | ap_start high until ap_ready; streams already open
// RUN       | streams open until both channels reach their lengths
// WAIT_DONE | all beats moved, waiting for ap_done
// DONE      | one-cycle done_o pulse, then back to IDLE
module dummy_hls_ip_ch_sched
  import dummy_hls_ip_package::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] in_len_i,
  input  logic [CNT_W-1:0] out_len_i,
  input  logic             in_en_i,
  input  logic             out_en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  output logic             hls_in_valid_o,
  input  logic             hls_in_ready_i,
  output logic [31:0]      hls_in_data_o,
  input  logic             hls_out_valid_i,
  output logic             hls_out_ready_o,
  input  logic [31:0]      hls_out_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic             hls_ap_start_o,
  input  logic             hls_ap_ready_i,
  input  logic             hls_ap_done_i,
  input  logic             hls_ap_idle_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] in_cnt_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  ch_sched_state_t state_q, state_d;
  logic            err_q, err_d;
  logic            done_pend_q, done_pend_d;
  logic            ap_start;

  logic chan_open;
  logic in_act_raw, out_act_raw;
  logic in_act, out_act;
  logic in_beat, out_beat;
  logic in_fin, out_fin, all_fin;
  logic accept;

  // clear_i closes the streams in the very cycle it is raised.
  assign chan_open = ((state_q == CS_START) || (state_q == CS_RUN)) && !clear_i;
  assign in_act    = in_act_raw && chan_open;
  assign out_act   = out_act_raw && chan_open;

  assign hls_in_valid_o  = in_valid_i && in_act;
  assign in_ready_o      = hls_in_ready_i && in_act;
  assign out_valid_o     = hls_out_valid_i && out_act;
  assign hls_out_ready_o = out_ready_i && out_act;
  assign hls_in_data_o   = in_data_i;
  assign out_data_o      = hls_out_data_i;

  assign in_beat  = in_valid_i && hls_in_ready_i && in_act;
  assign out_beat = hls_out_valid_i && out_ready_i && out_act;
  assign all_fin  = in_fin && out_fin;
  assign accept   = (state_q == CS_IDLE) && start_i && hls_ap_idle_i && !clear_i;

  dummy_hls_ip_beat_cnt #(.CNT_W(CNT_W)) i_in_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .load_zero_i (accept),
    .beat_i      (in_beat),
    .len_i       (in_len_i & {CNT_W{in_en_i}}),
    .cnt_o       (in_cnt_o),
    .act_o       (in_act_raw),
    .fin_o       (in_fin)
  );

  dummy_hls_ip_beat_cnt #(.CNT_W(CNT_W)) i_out_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .load_zero_i (accept),
    .beat_i      (out_beat),
    .len_i       (out_len_i & {CNT_W{out_en_i}}),
    .cnt_o       (out_cnt_o),
    .act_o       (out_act_raw),
    .fin_o       (out_fin)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    done_pend_d = done_pend_q;
    ap_start    = 1'b0;
    unique case (state_q)
      CS_IDLE: begin
        if (start_i && hls_ap_idle_i) begin
          state_d     = CS_START;
          err_d       = 1'b0;
          done_pend_d = 1'b0;
        end
      end
      CS_START: begin
        ap_start = 1'b1;
        if (hls_ap_done_i && !all_fin) begin
          err_d   = 1'b1;
          state_d = CS_DONE;
        end else if (hls_ap_done_i) begin
          state_d     = CS_WAIT_DONE;
          done_pend_d = 1'b1;
        end else if (hls_ap_ready_i) begin
          state_d = CS_RUN;
        end
      end
      CS_RUN: begin
        if (hls_ap_done_i && !all_fin) begin
          err_d   = 1'b1;
          state_d = CS_DONE;
        end else if (all_fin) begin
          // ap_done coinciding with the last beat is legal; remember it.
          state_d     = CS_WAIT_DONE;
          done_pend_d = hls_ap_done_i;
        end
      end
      CS_WAIT_DONE: begin
        if (hls_ap_done_i || done_pend_q) begin
          state_d     = CS_DONE;
          done_pend_d = 1'b0;
        end
      end
      CS_DONE: state_d = CS_IDLE;
      default: state_d = CS_IDLE;
    endcase
    if (clear_i) begin
      state_d     = CS_IDLE;
      err_d       = 1'b0;
      done_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CS_IDLE;
      err_q       <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign hls_ap_start_o = ap_start && !clear_i;
  assign busy_o         = (state_q != CS_IDLE);
  assign done_o         = (state_q == CS_DONE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_dummy_hls_ip_ch_sched.sv
// Directed bench for the dummy_hls_ip channel scheduler.
module tb_dummy_hls_ip_ch_sched;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear_i, start_i;
  logic [CNT_W-1:0] in_len_i, out_len_i;
  logic             in_en_i, out_en_i;
  logic             in_valid_i, in_ready_o;
  logic [31:0]      in_data_i;
  logic             hls_in_valid_o, hls_in_ready_i;
  logic [31:0]      hls_in_data_o;
  logic             hls_out_valid_i, hls_out_ready_o;
  logic [31:0]      hls_out_data_i;
  logic             out_valid_o, out_ready_i;
  logic [31:0]      out_data_o;
  logic             hls_ap_start_o, hls_ap_ready_i, hls_ap_done_i, hls_ap_idle_i;
  logic             busy_o, done_o, err_o;
  logic [CNT_W-1:0] in_cnt_o, out_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dummy_hls_ip_ch_sched #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i),
    .in_len_i(in_len_i), .out_len_i(out_len_i), .in_en_i(in_en_i), .out_en_i(out_en_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .hls_in_valid_o(hls_in_valid_o), .hls_in_ready_i(hls_in_ready_i), .hls_in_data_o(hls_in_data_o),
    .hls_out_valid_i(hls_out_valid_i), .hls_out_ready_o(hls_out_ready_o), .hls_out_data_i(hls_out_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .hls_ap_start_o(hls_ap_start_o), .hls_ap_ready_i(hls_ap_ready_i),
    .hls_ap_done_i(hls_ap_done_i), .hls_ap_idle_i(hls_ap_idle_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
  );

  task automatic idle_inputs();
    clear_i = 0; start_i = 0; in_valid_i = 0; hls_in_ready_i = 0;
    hls_out_valid_i = 0; out_ready_i = 0; hls_ap_ready_i = 0; hls_ap_done_i = 0;
    hls_ap_idle_i = 1; in_data_i = '0; hls_out_data_i = '0;
  endtask

  // Drives one job from cycle 0 (start pulse); ap_ready in cycle 1. ap_done goes
  // at done_cyc if >= 0, else done_delay cycles after the bench saw the last beat.
  task automatic run_job(input int in_len, input int out_len, input bit in_en, input bit out_en,
                         input int in_stop, input int done_cyc, input int done_delay,
                         input bit rand_bp, input int max_cyc,
                         output int n_in, output int n_out, output int n_done, output int done_at,
                         output int bad_data, output int viol,
                         output bit start1, output bit busy1, output bit err1, output bit start2);
    int in_eff, out_eff, fin_cyc;
    in_eff  = in_en ? in_len : 0;
    out_eff = out_en ? out_len : 0;
    n_in = 0; n_out = 0; n_done = 0; done_at = -1; bad_data = 0; viol = 0; fin_cyc = -1;
    start1 = 0; busy1 = 0; err1 = 0; start2 = 0;
    in_len_i = CNT_W'(in_len); out_len_i = CNT_W'(out_len); in_en_i = in_en; out_en_i = out_en;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      clear_i         = 0;
      start_i         = (c == 0);
      hls_ap_ready_i  = (c == 1);
      hls_ap_done_i   = (done_cyc >= 0) ? (c == done_cyc)
                                        : (fin_cyc >= 0 && c == fin_cyc + done_delay);
      in_valid_i      = (n_in < in_stop);
      in_data_i       = 32'h100 + 32'(n_in);
      hls_in_ready_i  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hls_out_valid_i = 1;
      hls_out_data_i  = 32'h200 + 32'(n_out);
      out_ready_i     = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (c == 1) begin start1 = hls_ap_start_o; busy1 = busy_o; err1 = err_o; end
      if (c == 2) start2 = hls_ap_start_o;
      if ((hls_in_valid_o || in_ready_o) && n_in >= in_eff) viol++;
      if ((out_valid_o || hls_out_ready_o) && n_out >= out_eff) viol++;
      if (hls_in_valid_o && hls_in_ready_i) begin
        if (hls_in_data_o !== 32'h100 + 32'(n_in)) bad_data++;
        n_in++;
      end
      if (out_valid_o && out_ready_i) begin
        if (out_data_o !== 32'h200 + 32'(n_out)) bad_data++;
        n_out++;
      end
      if (fin_cyc < 0 && n_in >= in_eff && n_out >= out_eff) fin_cyc = c;
      if (done_o) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    in_valid_i = 1; hls_in_ready_i = 1; hls_out_valid_i = 1; out_ready_i = 1;
    in_len_i = 5; out_len_i = 5; in_en_i = 1; out_en_i = 1;
    rst_n = 0;
    #12;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    total++; if (hls_ap_start_o !== 1'b0) begin bad++; $display("FAIL reset_ap_start: got %b want 0", hls_ap_start_o); end
    total++; if (in_cnt_o !== '0 || out_cnt_o !== '0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", in_cnt_o, out_cnt_o); end
    total++; if ({hls_in_valid_o, in_ready_o, out_valid_o, hls_out_ready_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_gating: got %b want 0000", {hls_in_valid_o, in_ready_o, out_valid_o, hls_out_ready_o});
    end
    idle_inputs();
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_normal();
    int ni, no, nd, da, bd, vi; bit s1, b1, e1, s2;
    run_job(8, 4, 1, 1, 100, -1, 2, 0, 60, ni, no, nd, da, bd, vi, s1, b1, e1, s2);
    total++; if (!(s1 && b1)) begin bad++; $display("FAIL normal_start_latency: got start=%b busy=%b want 1/1", s1, b1); end
    total++; if (s2 !== 1'b0) begin bad++; $display("FAIL normal_ap_start_drop: got %b want 0", s2); end
    total++; if (ni != 8 || no != 4) begin bad++; $display("FAIL normal_beats: got %0d/%0d want 8/4", ni, no); end
    total++; if (da != 11) begin bad++; $display("FAIL normal_done_cycle: got %0d want 11", da); end
    total++; if (nd != 1) begin bad++; $display("FAIL normal_done_pulses: got %0d want 1", nd); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL normal_err: got %b want 0", err_o); end
    total++; if (in_cnt_o !== 16'd8 || out_cnt_o !== 16'd4) begin bad++; $display("FAIL normal_cnt: got %0d/%0d want 8/4", in_cnt_o, out_cnt_o); end
    total++; if (vi != 0 || bd != 0) begin bad++; $display("FAIL normal_gating: got viol=%0d data=%0d want 0/0", vi, bd); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL normal_idle_after: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_backpressure();
    int ni, no, nd, da, bd, vi; bit s1, b1, e1, s2;
    run_job(16, 16, 1, 1, 100, -1, 1, 1, 400, ni, no, nd, da, bd, vi, s1, b1, e1, s2);
    total++; if (ni != 16 || no != 16) begin bad++; $display("FAIL bp_beats: got %0d/%0d want 16/16", ni, no); end
    total++; if (bd != 0) begin bad++; $display("FAIL bp_order: got %0d bad beats want 0", bd); end
    total++; if (vi != 0) begin bad++; $display("FAIL bp_past_len: got %0d want 0", vi); end
    total++; if (nd != 1 || da < 0) begin bad++; $display("FAIL bp_done: got pulses=%0d at=%0d want 1 pulse", nd, da); end
    total++; if (in_cnt_o !== 16'd16 || out_cnt_o !== 16'd16) begin bad++; $display("FAIL bp_cnt: got %0d/%0d want 16/16", in_cnt_o, out_cnt_o); end
  endtask

  task automatic test_early_done();
    int ni, no, nd, da, bd, vi; bit s1, b1, e1, s2;
    run_job(10, 0, 1, 1, 5, 6, 0, 0, 40, ni, no, nd, da, bd, vi, s1, b1, e1, s2);
    total++; if (da != 7 || nd != 1) begin bad++; $display("FAIL early_done_pulse: got at=%0d n=%0d want 7/1", da, nd); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL early_err: got %b want 1", err_o); end
    total++; if (in_cnt_o !== 16'd5) begin bad++; $display("FAIL early_in_cnt: got %0d want 5", in_cnt_o); end
  endtask

  task automatic test_disabled();
    int ni, no, nd, da, bd, vi; bit s1, b1, e1, s2;
    run_job(3, 7, 1, 0, 100, -1, 2, 0, 40, ni, no, nd, da, bd, vi, s1, b1, e1, s2);
    total++; if (e1 !== 1'b0) begin bad++; $display("FAIL dis_err_cleared_on_start: got %b want 0", e1); end
    total++; if (no != 0 || vi != 0) begin bad++; $display("FAIL dis_out_gated: got beats=%0d viol=%0d want 0/0", no, vi); end
    total++; if (da != 6 || nd != 1) begin bad++; $display("FAIL dis_done: got at=%0d n=%0d want 6/1", da, nd); end
    total++; if (in_cnt_o !== 16'd3 || out_cnt_o !== 16'd0 || err_o !== 1'b0) begin
      bad++; $display("FAIL dis_final: got in=%0d out=%0d err=%b want 3/0/0", in_cnt_o, out_cnt_o, err_o);
    end
  endtask

  task automatic test_same_cycle_done();
    int ni, no, nd, da, bd, vi; bit s1, b1, e1, s2;
    run_job(2, 2, 1, 1, 100, 2, 0, 0, 40, ni, no, nd, da, bd, vi, s1, b1, e1, s2);
    total++; if (da != 4 || err_o !== 1'b0) begin bad++; $display("FAIL same_cycle_done: got at=%0d err=%b want 4/0", da, err_o); end
    total++; if (in_cnt_o !== 16'd2 || out_cnt_o !== 16'd2) begin bad++; $display("FAIL same_cycle_cnt: got %0d/%0d want 2/2", in_cnt_o, out_cnt_o); end
  endtask

  task automatic test_zero_len();
    int ni, no, nd, da, bd, vi; bit s1, b1, e1, s2;
    run_job(0, 0, 1, 1, 100, 3, 0, 0, 40, ni, no, nd, da, bd, vi, s1, b1, e1, s2);
    total++; if (da != 4 || err_o !== 1'b0 || ni != 0 || no != 0) begin
      bad++; $display("FAIL zero_len: got at=%0d err=%b beats=%0d/%0d want 4/0/0/0", da, err_o, ni, no);
    end
  endtask

  task automatic test_start_ignored();
    idle_inputs();
    @(posedge clk); #1; start_i = 1; hls_ap_idle_i = 0; in_len_i = 2; out_len_i = 0; in_en_i = 1; out_en_i = 1;
    @(posedge clk); #1; start_i = 0; hls_ap_idle_i = 1; #1;
    total++; if (busy_o !== 1'b0 || hls_ap_start_o !== 1'b0) begin
      bad++; $display("FAIL ign_not_idle: got busy=%b start=%b want 0/0", busy_o, hls_ap_start_o);
    end
    in_valid_i = 1; in_data_i = 32'h55;
    start_i = 1;                                    // accepted: cycle 0
    @(posedge clk); #1; start_i = 1;                // START, start ignored
    @(posedge clk); #1; start_i = 0; hls_ap_ready_i = 1; hls_in_ready_i = 1; // START + one beat
    @(posedge clk); #1; hls_ap_ready_i = 0; hls_in_ready_i = 0; start_i = 1; // RUN, stalled
    @(posedge clk); #1; start_i = 0; #1;
    total++; if (busy_o !== 1'b1 || hls_ap_start_o !== 1'b0 || in_cnt_o !== 16'd1) begin
      bad++; $display("FAIL ign_busy: got busy=%b start=%b in_cnt=%0d want 1/0/1", busy_o, hls_ap_start_o, in_cnt_o);
    end
    clear_i = 1;
    @(posedge clk); #1; idle_inputs();
  endtask

  task automatic test_abort();
    int nd = 0;
    int ni, no, nd2, da, bd, vi; bit s1, b1, e1, s2;
    idle_inputs();
    in_len_i = 6; out_len_i = 6; in_en_i = 1; out_en_i = 1;
    in_valid_i = 1; hls_in_ready_i = 1; hls_out_valid_i = 1; out_ready_i = 1;
    @(posedge clk); #1; start_i = 1;
    @(posedge clk); #1; start_i = 0; hls_ap_ready_i = 1;
    @(posedge clk); #1; hls_ap_ready_i = 0;
    @(posedge clk); #1; clear_i = 1; #1;
    total++; if ({hls_in_valid_o, in_ready_o, out_valid_o, hls_out_ready_o} !== 4'b0000) begin
      bad++; $display("FAIL abort_gating_same_cycle: got %b want 0000", {hls_in_valid_o, in_ready_o, out_valid_o, hls_out_ready_o});
    end
    if (done_o) nd++;
    @(posedge clk); #1; clear_i = 0; #1;
    total++; if (busy_o !== 1'b0 || in_cnt_o !== '0 || hls_ap_start_o !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b in_cnt=%0d start=%b want 0/0/0", busy_o, in_cnt_o, hls_ap_start_o);
    end
    for (int i = 0; i < 5; i++) begin
      if (done_o) nd++;
      @(posedge clk); #2;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    idle_inputs();
    run_job(2, 1, 1, 1, 100, -1, 1, 0, 40, ni, no, nd2, da, bd, vi, s1, b1, e1, s2);
    total++; if (ni != 2 || no != 1 || nd2 != 1 || err_o !== 1'b0 || in_cnt_o !== 16'd2 || out_cnt_o !== 16'd1) begin
      bad++; $display("FAIL abort_next_job: got beats=%0d/%0d done=%0d err=%b cnt=%0d/%0d want 2/1/1/0/2/1",
                      ni, no, nd2, err_o, in_cnt_o, out_cnt_o);
    end
  endtask

  initial begin
    idle_inputs();
    in_len_i = '0; out_len_i = '0; in_en_i = 0; out_en_i = 0;
    test_reset();
    test_normal();
    test_backpressure();
    test_early_done();
    test_disabled();
    test_same_cycle_done();
    test_zero_len();
    test_start_ignored();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
